regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised two-write-port register file with write-to-read bypass and a per-register busy scoreboard, the successor to the single-write-port MIPS register file. It sits in the decode stage: read ports feed operand muxes, write ports take writeback from the main and secondary (multicycle/load) pipes, and the busy outputs drive the hazard/stall unit. Register 0 is hardwired to zero and never busy.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)

Ports:
- CLK_RegFile  in  1  clock; all state updates on rising edge
- RST_RegFile  in  1  asynchronous, active-low reset
- RA  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- RD  out  NUM_RD*DATA_W  read data, same packing
- RBUSY  out  NUM_RD  port k source register has a pending write
- WE0, WE1  in  1 each  write enables
- WA0, WA1  in  ADDR_W each  write addresses
- WD0, WD1  in  DATA_W each  write data
- ISSUE_EN  in  1  mark ISSUE_ADDR busy
- ISSUE_ADDR  in  ADDR_W  destination of newly issued instruction
- FLUSH  in  1  synchronous clear of all busy bits
- BUSY_VEC  out  2**ADDR_W  raw scoreboard state

## Operation
- Write: on rising edge, WEn=1 and WAn!=0 stores WDn. WAn=0 writes are discarded.
- Same address on both write ports: port 1 wins (later pipe).
- Read: combinational. RA=0 → RD=0. Else if WE1 & WA1==RA → WD1; else if WE0 & WA0==RA → WD0; else stored value (write-through bypass, same-cycle priority matches the storage priority).
- Scoreboard: busy[r] set by ISSUE_EN at ISSUE_ADDR; cleared by any enabled write to r. ISSUE and write to same r in one cycle → busy stays/becomes 1 (new producer wins). busy[0] always 0.
- FLUSH clears all busy bits; ISSUE_EN in the same cycle is ignored. FLUSH does not affect register contents or writes that cycle.
- RBUSY[k] = busy[RA_k] & ~(write to RA_k this cycle), i.e. a writeback in the current cycle releases the stall with the bypassed value. RA_k=0 → RBUSY[k]=0.

## Timing
- Reset (RST_RegFile low, any time, asynchronous): all registers 0, all busy 0; RD=0, RBUSY=0, BUSY_VEC=0 while asserted. Writes/issues during reset are lost.
- Write latency: data visible on RD same cycle (bypass), from storage from the next cycle.
- Issue latency: busy visible on BUSY_VEC/RBUSY one cycle after the ISSUE_EN edge.
- Clear latency: RBUSY drops combinationally in the write cycle; BUSY_VEC drops one cycle after.
- No handshake; all inputs sampled every edge, no backpressure.

## Structure
- Shared package regfile_pkg: DATA_W/ADDR_W defaults, ZERO_REG constant (0).
- One natural sub-module: regfile_scoreboard_busy (busy-bit array, set/clear/flush priority, RBUSY generation); storage and bypass muxes stay in the top.
- Generate loop over NUM_RD for read/bypass logic.

## Test plan
- Reset mid-run: load r5=0xDEADBEEF, issue r5, assert RST_RegFile between edges → RD(r5)=0, BUSY_VEC=0 immediately.
- Bypass: WE0, WA0=7, WD0=0x11 with RA0=7 same cycle → RD0=0x11; next cycle without write → RD0=0x11 from storage.
- Dual-write conflict: WA0=WA1=3, WD0=0xAAAA, WD1=0x5555 → RD(r3)=0x5555 same and next cycle.
- r0: WE0, WA0=0, WD0=0xFFFF_FFFF and ISSUE_ADDR=0 → RD(r0)=0, RBUSY=0, BUSY_VEC[0]=0.
- Scoreboard: issue r9 → next cycle RBUSY=1 for RA=9; writeback r9 (WD1=0x42) → RBUSY=0 and RD=0x42 same cycle; issue+write r9 same cycle → busy[9]=1 after edge.
- FLUSH with ISSUE_EN (r4) and busy r2,r6 → BUSY_VEC all zero next cycle; register contents unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and constants for the two-write-port register file
`timescale 1ns/1ps
package regfile_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int ZERO_REG   = 0;
endpackage

// File: rtl/regfile_scoreboard_busy.sv
// regfile_scoreboard_busy: per-register busy bits with flush/issue/writeback priority and read-port stall flags
`timescale 1ns/1ps
module regfile_scoreboard_busy
   import regfile_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NUM_RD = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] ra,
   input  logic                     we0,
   input  logic [ADDR_W-1:0]        wa0,
   input  logic                     we1,
   input  logic [ADDR_W-1:0]        wa1,
   input  logic                     issue_en,
   input  logic [ADDR_W-1:0]        issue_addr,
   input  logic                     flush,
   output logic [NUM_RD-1:0]        rbusy,
   output logic [2**ADDR_W-1:0]     busy_vec
);
   localparam int DEPTH = 2**ADDR_W;

   // flush beats issue, issue beats writeback clear, r0 is never busy
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         busy_vec <= '0;
      else
         for (int r = 0; r < DEPTH; r++)
            busy_vec[r] <= (r == ZERO_REG || flush) ? 1'b0 :
                           (issue_en && issue_addr == ADDR_W'(r)) ? 1'b1 :
                           ((we0 && wa0 == ADDR_W'(r)) || (we1 && wa1 == ADDR_W'(r))) ? 1'b0 :
                           busy_vec[r];

   // a writeback landing this cycle releases the stall, matching the bypassed data
   genvar k;
   generate
      for (k = 0; k < NUM_RD; k++) begin : g_rbusy
         assign rbusy[k] = busy_vec[ra[k*ADDR_W +: ADDR_W]] &
                           ~((we0 && wa0 == ra[k*ADDR_W +: ADDR_W]) ||
                             (we1 && wa1 == ra[k*ADDR_W +: ADDR_W]));
      end
   endgenerate
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: two-write-port register file with write-through bypass and busy scoreboard
`timescale 1ns/1ps
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NUM_RD = 2
) (
   input  logic                     CLK_RegFile,
   input  logic                     RST_RegFile,
   input  logic [NUM_RD*ADDR_W-1:0] RA,
   output logic [NUM_RD*DATA_W-1:0] RD,
   output logic [NUM_RD-1:0]        RBUSY,
   input  logic                     WE0,
   input  logic                     WE1,
   input  logic [ADDR_W-1:0]        WA0,
   input  logic [ADDR_W-1:0]        WA1,
   input  logic [DATA_W-1:0]        WD0,
   input  logic [DATA_W-1:0]        WD1,
   input  logic                     ISSUE_EN,
   input  logic [ADDR_W-1:0]        ISSUE_ADDR,
   input  logic                     FLUSH,
   output logic [2**ADDR_W-1:0]     BUSY_VEC
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // storage update; port 1 overrides port 0 on the same address, r0 stays zero
   always_ff @(posedge CLK_RegFile or negedge RST_RegFile)
      if (!RST_RegFile)
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      else
         for (int i = 1; i < DEPTH; i++)
            mem[i] <= (WE1 && WA1 == ADDR_W'(i)) ? WD1 :
                      (WE0 && WA0 == ADDR_W'(i)) ? WD0 : mem[i];

   // read ports: same-cycle writes are forwarded with the storage priority
   genvar k;
   generate
      for (k = 0; k < NUM_RD; k++) begin : g_rd
         logic [ADDR_W-1:0] a;
         assign a = RA[k*ADDR_W +: ADDR_W];
         assign RD[k*DATA_W +: DATA_W] =
            (!RST_RegFile || a == ADDR_W'(ZERO_REG)) ? '0 :
            (WE1 && WA1 == a) ? WD1 :
            (WE0 && WA0 == a) ? WD0 : mem[a];
      end
   endgenerate

   regfile_scoreboard_busy #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) u_busy (
      .clk       (CLK_RegFile),
      .rst_n     (RST_RegFile),
      .ra        (RA),
      .we0       (WE0),
      .wa0       (WA0),
      .we1       (WE1),
      .wa1       (WA1),
      .issue_en  (ISSUE_EN),
      .issue_addr(ISSUE_ADDR),
      .flush     (FLUSH),
      .rbusy     (RBUSY),
      .busy_vec  (BUSY_VEC)
   );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed plus randomized checks against an array-based reference model
`timescale 1ns/1ps
module tb_regfile_scoreboard;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  ra0, ra1;
   logic [9:0]  ra;
   logic [63:0] rd;
   logic [1:0]  rbusy;
   logic        we0, we1, issue_en, flush;
   logic [4:0]  wa0, wa1, issue_addr;
   logic [31:0] wd0, wd1;
   logic [31:0] busy_vec;

   logic [31:0] m_regs [32];
   bit          m_busy [32];
   int          checks = 0;
   int          failures = 0;

   assign ra = {ra1, ra0};

   regfile_scoreboard dut (
      .CLK_RegFile(clk),
      .RST_RegFile(rst_n),
      .RA         (ra),
      .RD         (rd),
      .RBUSY      (rbusy),
      .WE0        (we0),
      .WE1        (we1),
      .WA0        (wa0),
      .WA1        (wa1),
      .WD0        (wd0),
      .WD1        (wd1),
      .ISSUE_EN   (issue_en),
      .ISSUE_ADDR (issue_addr),
      .FLUSH      (flush),
      .BUSY_VEC   (busy_vec)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (we1 && wa1 == a) return wd1;
      if (we0 && wa0 == a) return wd0;
      return m_regs[a];
   endfunction

   function automatic logic exp_rbusy(input logic [4:0] a);
      return m_busy[a] && !((we0 && wa0 == a) || (we1 && wa1 == a));
   endfunction

   function automatic logic [31:0] exp_busy_vec();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = 0;
         m_busy[i] = 0;
      end
   endtask

   task automatic idle();
      we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
      issue_en = 0; issue_addr = 0; flush = 0;
   endtask

   // compare every output with the model, then clock and advance the model
   task automatic step();
      #2;
      check("rd0", {32'h0, rd[31:0]}, {32'h0, exp_rd(ra0)});
      check("rd1", {32'h0, rd[63:32]}, {32'h0, exp_rd(ra1)});
      check("rbusy", {62'h0, rbusy}, {62'h0, exp_rbusy(ra1), exp_rbusy(ra0)});
      check("busy_vec", {32'h0, busy_vec}, {32'h0, exp_busy_vec()});
      @(posedge clk);
      if (we0 && wa0 != 0) m_regs[wa0] = wd0;
      if (we1 && wa1 != 0) m_regs[wa1] = wd1;
      if (flush) begin
         for (int i = 0; i < 32; i++) m_busy[i] = 0;
      end else begin
         if (we0) m_busy[wa0] = 0;
         if (we1) m_busy[wa1] = 0;
         if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1;
      end
      @(negedge clk);
   endtask

   initial begin
      idle(); ra0 = 0; ra1 = 0; model_reset();
      @(negedge clk);
      ra0 = 5;
      #1;
      check("reset_rd0", {32'h0, rd[31:0]}, 64'h0);
      check("reset_busy", {32'h0, busy_vec}, 64'h0);
      check("reset_rbusy", {62'h0, rbusy}, 64'h0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      // bypass then storage read
      we0 = 1; wa0 = 7; wd0 = 32'h11; ra0 = 7;
      #1 check("bypass_same", {32'h0, rd[31:0]}, 64'h11);
      step();
      idle();
      #1 check("bypass_next", {32'h0, rd[31:0]}, 64'h11);
      step();

      // dual write conflict
      we0 = 1; we1 = 1; wa0 = 3; wa1 = 3; wd0 = 32'hAAAA; wd1 = 32'h5555; ra0 = 3; ra1 = 3;
      #1 check("dual_same", {32'h0, rd[31:0]}, 64'h5555);
      step();
      idle();
      #1 check("dual_next", {32'h0, rd[63:32]}, 64'h5555);
      step();

      // register zero
      we0 = 1; wa0 = 0; wd0 = 32'hFFFF_FFFF; issue_en = 1; issue_addr = 0; ra0 = 0;
      #1 check("r0_same", {32'h0, rd[31:0]}, 64'h0);
      step();
      idle();
      #1;
      check("r0_rd", {32'h0, rd[31:0]}, 64'h0);
      check("r0_rbusy", {63'h0, rbusy[0]}, 64'h0);
      check("r0_busy", {63'h0, busy_vec[0]}, 64'h0);
      step();

      // scoreboard set / clear / reissue
      issue_en = 1; issue_addr = 9;
      step();
      idle(); ra0 = 9;
      #1 check("sb_set", {63'h0, rbusy[0]}, 64'h1);
      step();
      we1 = 1; wa1 = 9; wd1 = 32'h42;
      #1;
      check("sb_release", {63'h0, rbusy[0]}, 64'h0);
      check("sb_bypass", {32'h0, rd[31:0]}, 64'h42);
      step();
      idle(); ra0 = 9;
      issue_en = 1; issue_addr = 9; we0 = 1; wa0 = 9; wd0 = 32'h77;
      step();
      idle();
      #1 check("sb_reissue", {63'h0, busy_vec[9]}, 64'h1);
      step();

      // flush
      issue_en = 1; issue_addr = 2; step();
      issue_en = 1; issue_addr = 6; step();
      idle(); flush = 1; issue_en = 1; issue_addr = 4; ra0 = 3;
      step();
      idle(); ra0 = 3; ra1 = 7;
      #1;
      check("flush_vec", {32'h0, busy_vec}, 64'h0);
      check("flush_r3", {32'h0, rd[31:0]}, 64'h5555);
      check("flush_r7", {32'h0, rd[63:32]}, 64'h11);
      step();

      // reset mid-run
      we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; issue_en = 1; issue_addr = 5;
      step();
      idle(); ra0 = 5;
      #1 check("pre_reset_rd", {32'h0, rd[31:0]}, 64'hDEADBEEF);
      #1 rst_n = 0;
      #1;
      check("midreset_rd", {32'h0, rd[31:0]}, 64'h0);
      check("midreset_vec", {32'h0, busy_vec}, 64'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      step();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         we0 = 1'($urandom); wa0 = 5'($urandom); wd0 = $urandom;
         we1 = 1'($urandom); wa1 = ($urandom % 3 == 0) ? wa0 : 5'($urandom); wd1 = $urandom;
         issue_en = 1'($urandom); issue_addr = ($urandom % 4 == 0) ? wa1 : 5'($urandom);
         flush = ($urandom % 16 == 0);
         ra0 = ($urandom % 3 == 0) ? wa0 : 5'($urandom);
         ra1 = ($urandom % 3 == 0) ? wa1 : 5'($urandom);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
